// File: rtl/clk_ctrl_pkg.sv
// Shared constants for the clock-divider controller: FSM encoding and divisor limits.
package clk_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Smallest divisor that still yields a distinct high and low phase.
    localparam int MIN_DIV = 2;

    // Divisor each channel holds out of reset.
    localparam int RST_DIV = 2;

endpackage

// File: rtl/clk_div_chan.sv
// One clock-enable divider channel. Divisor and enable only change on load,
// and the controller only loads at a period boundary, so div_clk never runts.
module clk_div_chan
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             en,
    input  logic             load,
    output logic             div_clk,
    output logic             strobe,
    output logic             active,
    output logic             at_boundary
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;
    logic             en_q;
    logic             last;

    // A stopped channel is always at a boundary; a running one on its last count.
    always_comb begin
        last        = (cnt_q == div_q - DIV_W'(1));
        at_boundary = !en_q || last;
    end

    // Period counter; a load restarts the period at count 0.
    // A disable request leaves the stored divisor untouched.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= DIV_W'(RST_DIV);
            en_q  <= 1'b0;
        end else if (load) begin
            if (en) begin
                div_q <= div;
            end
            en_q  <= en;
            cnt_q <= '0;
        end else if (en_q) begin
            cnt_q <= last ? '0 : cnt_q + DIV_W'(1);
        end
    end

    // Registered outputs trail the counter by one cycle; odd divisors get the shorter high phase.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_clk <= 1'b0;
            strobe  <= 1'b0;
        end else begin
            div_clk <= en_q && (cnt_q < (div_q >> 1));
            strobe  <= en_q && (cnt_q == '0);
        end
    end

    assign active = en_q;

endmodule

// File: rtl/clock_div_ctrl.sv
// Runtime controller for NUM_CH programmable clock-enable dividers.
// Takes one config request at a time and applies it at the target channel's
// period boundary.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | ready for a request; cfg_ready high
//   ST_CHECK | validate captured request; reject pulses cfg_err
//   ST_WAIT  | hold until the target channel reaches its boundary
//   ST_DONE  | change applied; cfg_done high for this one cycle
module clock_div_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8,
    parameter int CH_W   = 2
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_en,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] strobe,
    output logic [NUM_CH-1:0] ch_active
);

    logic [1:0]        state;
    logic [CH_W-1:0]   req_ch;
    logic [DIV_W-1:0]  req_div;
    logic              req_en;
    logic              err_q;
    logic              reject;
    logic              apply;
    logic [NUM_CH-1:0] at_boundary;
    logic [NUM_CH-1:0] load;

    // A request is illegal if it names a missing channel or asks to run below the minimum divisor.
    always_comb begin
        reject = (32'(req_ch) >= NUM_CH) || (req_en && (req_div < DIV_W'(MIN_DIV)));
    end

    // Request sequencing; the captured fields decouple the channel from later bus activity.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            req_ch  <= '0;
            req_div <= '0;
            req_en  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        req_ch  <= cfg_ch;
                        req_div <= cfg_div;
                        req_en  <= cfg_en;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (reject) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (apply) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = (state == ST_IDLE);
    assign cfg_done  = (state == ST_DONE);
    assign cfg_err   = err_q;
    assign apply     = |load;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = (state == ST_WAIT) && (req_ch == CH_W'(i)) && at_boundary[i];

        clk_div_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk_in      (clk_in),
            .rst_n       (rst_n),
            .div         (req_div),
            .en          (req_en),
            .load        (load[i]),
            .div_clk     (div_clk[i]),
            .strobe      (strobe[i]),
            .active      (ch_active[i]),
            .at_boundary (at_boundary[i])
        );
    end

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed bench for clock_div_ctrl. A second instance with three channels
// exercises the out-of-range channel reject, which four channels cannot express.
module tb_clock_div_ctrl;

    localparam int BIG = 32'h3fff_ffff;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       valid3 = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       cfg_en = 1'b0;
    logic       cfg_ready, cfg_done, cfg_err;
    logic [3:0] div_clk, strobe, ch_active;
    logic       ready3, done3, err3;
    logic [2:0] div_clk3, strobe3, act3;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Expected per-channel state: current segment (m_*) and a pending change taking effect at edge chg.
    int m_en[4], m_div[4], m_anc[4];
    int n_en[4], n_div[4], n_anc[4], chg[4];

    clock_div_ctrl #(.NUM_CH(4), .DIV_W(8), .CH_W(2)) u_dut (
        .clk_in(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .div_clk(div_clk), .strobe(strobe), .ch_active(ch_active)
    );

    clock_div_ctrl #(.NUM_CH(3), .DIV_W(8), .CH_W(2)) u_dut3 (
        .clk_in(clk), .rst_n(rst_n), .cfg_valid(valid3), .cfg_ready(ready3),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en), .cfg_done(done3),
        .cfg_err(err3), .div_clk(div_clk3), .strobe(strobe3), .ch_active(act3)
    );

    always #5 clk = ~clk;

    // Edge counter: at the falling edge after rising edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic exp_clk(int ch, int c);
        int en, dv, an;
        if (c > chg[ch]) begin en = n_en[ch]; dv = n_div[ch]; an = n_anc[ch]; end
        else begin en = m_en[ch]; dv = m_div[ch]; an = m_anc[ch]; end
        if (en == 0) return 1'b0;
        return ((c - an) % dv) < (dv / 2);
    endfunction

    function automatic logic exp_stb(int ch, int c);
        int en, dv, an;
        if (c > chg[ch]) begin en = n_en[ch]; dv = n_div[ch]; an = n_anc[ch]; end
        else begin en = m_en[ch]; dv = m_div[ch]; an = m_anc[ch]; end
        if (en == 0) return 1'b0;
        return ((c - an) % dv) == 0;
    endfunction

    function automatic logic exp_act(int ch, int c);
        return (c >= chg[ch]) ? (n_en[ch] != 0) : (m_en[ch] != 0);
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < 4; ch++) begin
            m_en[ch] = 0; m_div[ch] = 2; m_anc[ch] = 0;
            n_en[ch] = 0; n_div[ch] = 2; n_anc[ch] = 0; chg[ch] = BIG;
        end
    endtask

    // Expected apply edge: first boundary edge once the FSM has sat in WAIT for a cycle.
    task automatic plan(input int ch, input int t0, input int en, input int dv, output int e);
        e = t0 + 2;
        if (m_en[ch] != 0) begin
            while (((e - m_anc[ch]) % m_div[ch]) != m_div[ch] - 1) e++;
        end
        n_en[ch]  = en;
        n_div[ch] = (en != 0) ? dv : m_div[ch];
        n_anc[ch] = e + 1;
        chg[ch]   = e;
    endtask

    task automatic commit(input int ch);
        m_en[ch] = n_en[ch]; m_div[ch] = n_div[ch]; m_anc[ch] = n_anc[ch]; chg[ch] = BIG;
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer edge.
    task automatic send(input int ch, input int dv, input int en, output int t0);
        int n;
        cfg_ch = 2'(ch); cfg_div = 8'(dv); cfg_en = en[0]; cfg_valid = 1'b1;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            tests++; fails++;
            $display("FAIL send_ready_timeout: ready=%b want 1", cfg_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic step_cmp(input int n, output int bad, output int first_done,
                            output int n_done, output int n_err);
        bad = 0; first_done = -1; n_done = 0; n_err = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int ch = 0; ch < 4; ch++) begin
                if (div_clk[ch] !== exp_clk(ch, cyc) || strobe[ch] !== exp_stb(ch, cyc) ||
                    ch_active[ch] !== exp_act(ch, cyc)) bad++;
            end
            if (cfg_done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = cyc;
            end
            if (cfg_err === 1'b1) n_err++;
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({cfg_ready, cfg_done, cfg_err} !== 3'b100) begin
            fails++; $display("FAIL reset_handshake: got %b want 100", {cfg_ready, cfg_done, cfg_err});
        end
        tests++;
        if ({div_clk, strobe, ch_active} !== 12'h000) begin
            fails++; $display("FAIL reset_channels: got %h want 000", {div_clk, strobe, ch_active});
        end
        tests++;
        if ({ready3, done3, err3, act3} !== 6'b100000) begin
            fails++; $display("FAIL reset_dut3: got %b want 100000", {ready3, done3, err3, act3});
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({cfg_ready, div_clk, ch_active} !== 9'b1_0000_0000) begin
            fails++; $display("FAIL reset_release: got %b want 100000000", {cfg_ready, div_clk, ch_active});
        end
    endtask

    task automatic test_enable_ch0();
        int t0, e, bad, fd, nd, ne, hi, stb;
        send(0, 28, 1, t0);
        plan(0, t0, 1, 28, e);
        step_cmp(3, bad, fd, nd, ne);
        tests++;
        if (fd < 0 || fd - t0 > 3 || fd != e) begin
            fails++; $display("FAIL en_ch0_done_latency: got %0d want %0d", fd - t0, e - t0);
        end
        commit(0);
        hi = 0; stb = 0;
        for (int i = 0; i < 28; i++) begin
            if (i > 0) @(negedge clk);
            hi += int'(div_clk[0]);
            stb += int'(strobe[0]);
        end
        tests++;
        if (hi != 14 || stb != 1) begin
            fails++; $display("FAIL en_ch0_duty: high=%0d strobes=%0d want 14 1", hi, stb);
        end
        step_cmp(56, bad, fd, nd, ne);
        tests++;
        if (bad != 0 || nd != 0 || ne != 0) begin
            fails++; $display("FAIL en_ch0_run: bad=%0d done=%0d err=%0d want 0 0 0", bad, nd, ne);
        end
    endtask

    task automatic test_enable_ch1();
        int t0, e, bad, fd, nd, ne, hi, stb;
        send(1, 5, 1, t0);
        plan(1, t0, 1, 5, e);
        step_cmp(3, bad, fd, nd, ne);
        tests++;
        if (fd != t0 + 2 || bad != 0) begin
            fails++; $display("FAIL en_ch1_apply: done_at=%0d bad=%0d want %0d 0", fd - t0, bad, 2);
        end
        commit(1);
        hi = 0; stb = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            hi += int'(div_clk[1]);
            stb += int'(strobe[1]);
        end
        tests++;
        if (hi != 2 || stb != 1) begin
            fails++; $display("FAIL en_ch1_duty: high=%0d strobes=%0d want 2 1", hi, stb);
        end
        step_cmp(30, bad, fd, nd, ne);
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL en_ch1_ch0_undisturbed: bad=%0d want 0", bad);
        end
    endtask

    task automatic test_redivide();
        int t0, e, bad, fd, nd, ne, n;
        n = 0;
        while (((cyc - m_anc[0]) % 28) != 3 && n < 40) begin @(negedge clk); n++; end
        send(0, 4, 1, t0);
        plan(0, t0, 1, 4, e);
        step_cmp(32, bad, fd, nd, ne);
        tests++;
        if (fd - t0 != 23 || nd != 1) begin
            fails++; $display("FAIL redivide_boundary: done_at=%0d count=%0d want 23 1", fd - t0, nd);
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL redivide_waveform: bad=%0d want 0", bad);
        end
        commit(0);
    endtask

    task automatic test_reject();
        int t0, e, bad, fd, nd, ne, first_err, ecount, dcount;
        send(2, 1, 1, t0);
        step_cmp(5, bad, fd, nd, ne);
        tests++;
        if (ne != 1 || nd != 0 || bad != 0) begin
            fails++; $display("FAIL reject_div1: err=%0d done=%0d bad=%0d want 1 0 0", ne, nd, bad);
        end
        send(0, 0, 1, t0);
        step_cmp(5, bad, fd, nd, ne);
        tests++;
        if (ne != 1 || nd != 0 || bad != 0) begin
            fails++; $display("FAIL reject_div0_running: err=%0d done=%0d bad=%0d want 1 0 0", ne, nd, bad);
        end
        send(2, 0, 0, t0);
        plan(2, t0, 0, 0, e);
        step_cmp(4, bad, fd, nd, ne);
        tests++;
        if (ne != 0 || nd != 1 || bad != 0) begin
            fails++; $display("FAIL disable_div_ignored: err=%0d done=%0d bad=%0d want 0 1 0", ne, nd, bad);
        end
        commit(2);
        cfg_ch = 2'd3; cfg_div = 8'd5; cfg_en = 1'b1; valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid3 = 1'b0;
        t0 = cyc;
        first_err = -1; ecount = 0; dcount = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (err3 === 1'b1) begin ecount++; if (first_err < 0) first_err = cyc; end
            if (done3 === 1'b1) dcount++;
        end
        tests++;
        if (ecount != 1 || dcount != 0 || first_err != t0 + 1 || act3 !== 3'b000) begin
            fails++; $display("FAIL reject_bad_channel: err=%0d done=%0d err_at=%0d act=%b want 1 0 1 000",
                              ecount, dcount, first_err - t0, act3);
        end
    endtask

    task automatic test_back_to_back();
        int t0, e2, e3, bad, fd, nd, ne;
        logic [7:0] rdy, dn;
        cfg_ch = 2'd2; cfg_div = 8'd3; cfg_en = 1'b1; cfg_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t0 = cyc;
        cfg_ch = 2'd3; cfg_div = 8'd6; cfg_en = 1'b1;
        plan(2, t0, 1, 3, e2);
        plan(3, t0 + 4, 1, 6, e3);
        rdy = '0; dn = '0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            rdy[k] = cfg_ready;
            dn[k]  = cfg_done;
            if (k == 4) cfg_valid = 1'b0;
        end
        tests++;
        if (rdy !== 8'b1000_1000) begin
            fails++; $display("FAIL b2b_ready: got %b want 10001000", rdy);
        end
        tests++;
        if (dn !== 8'b0100_0100) begin
            fails++; $display("FAIL b2b_done: got %b want 01000100", dn);
        end
        commit(2);
        commit(3);
        step_cmp(24, bad, fd, nd, ne);
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL b2b_channels: bad=%0d want 0", bad);
        end
    endtask

    task automatic test_disable_ch1();
        int t0, e, bad, fd, nd, ne, n;
        n = 0;
        while (((cyc - m_anc[1]) % 5) != 2 && n < 10) begin @(negedge clk); n++; end
        send(1, 7, 0, t0);
        plan(1, t0, 0, 0, e);
        step_cmp(12, bad, fd, nd, ne);
        tests++;
        if (fd - t0 != 6 || bad != 0) begin
            fails++; $display("FAIL disable_ch1_boundary: done_at=%0d bad=%0d want 6 0", fd - t0, bad);
        end
        commit(1);
        tests++;
        if ({div_clk[1], strobe[1], ch_active[1]} !== 3'b000) begin
            fails++; $display("FAIL disable_ch1_idle: got %b want 000", {div_clk[1], strobe[1], ch_active[1]});
        end
    endtask

    task automatic test_reset_in_wait();
        int t0, bad, fd, nd, ne, n;
        n = 0;
        while (((cyc - m_anc[3]) % 6) != 0 && n < 10) begin @(negedge clk); n++; end
        send(3, 4, 1, t0);
        @(negedge clk);
        tests++;
        if (cfg_ready !== 1'b0 || cfg_done !== 1'b0) begin
            fails++; $display("FAIL wait_state: ready=%b done=%b want 0 0", cfg_ready, cfg_done);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({cfg_ready, cfg_done, cfg_err, div_clk, strobe, ch_active} !== 15'b100_0000_0000_0000) begin
            fails++; $display("FAIL async_reset: got %b want 100000000000000",
                              {cfg_ready, cfg_done, cfg_err, div_clk, strobe, ch_active});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step_cmp(10, bad, fd, nd, ne);
        tests++;
        if (nd != 0 || bad != 0) begin
            fails++; $display("FAIL reset_abort: done=%0d bad=%0d want 0 0", nd, bad);
        end
    endtask

    task automatic test_min_max_div();
        int t0, e, bad, fd, nd, ne, hi, stb;
        send(0, 2, 1, t0);
        plan(0, t0, 1, 2, e);
        step_cmp(10, bad, fd, nd, ne);
        tests++;
        if (fd != t0 + 2 || bad != 0) begin
            fails++; $display("FAIL min_div2: done_at=%0d bad=%0d want 2 0", fd - t0, bad);
        end
        commit(0);
        send(1, 255, 1, t0);
        plan(1, t0, 1, 255, e);
        step_cmp(3, bad, fd, nd, ne);
        commit(1);
        hi = 0; stb = 0;
        for (int i = 0; i < 255; i++) begin
            if (i > 0) @(negedge clk);
            hi += int'(div_clk[1]);
            stb += int'(strobe[1]);
        end
        tests++;
        if (hi != 127 || stb != 1 || fd != t0 + 2) begin
            fails++; $display("FAIL max_div255: high=%0d strobes=%0d done_at=%0d want 127 1 2", hi, stb, fd - t0);
        end
        step_cmp(20, bad, fd, nd, ne);
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL max_div_run: bad=%0d want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_enable_ch0();
        test_enable_ch1();
        test_redivide();
        test_reject();
        test_back_to_back();
        test_disable_ch1();
        test_reset_in_wait();
        test_min_max_div();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
